// File: rtl/led_report_pkg.sv
// Shared types, ASCII constants and format helpers for the LED status reporter.
// Define LED_REPORT_HEX_EN to switch the payload from binary digits to hex digits.
package led_report_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0] CHAR_L  = 8'h4C;
  localparam logic [7:0] CHAR_EQ = 8'h3D;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_1  = 8'h31;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Payload digit count; the framing adds 'L', '=', CR and LF around it.
  function automatic int payload_len(input int num_leds);
`ifdef LED_REPORT_HEX_EN
    return (num_leds + 3) / 4;
`else
    return num_leds;
`endif
  endfunction

  function automatic int msg_len(input int num_leds);
    return payload_len(num_leds) + 4;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] nib);
    if (nib < 4'd10) return CHAR_0 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/led_report_fmt.sv
// Combinational message byte selector: (snapshot, byte index) -> ASCII byte.
// Honors LED_REPORT_HEX_EN for the payload encoding; framing is identical in both modes.
module led_report_fmt
  import led_report_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int IDX_W    = 4
) (
  input  logic [NUM_LEDS-1:0] snapshot,
  input  logic [IDX_W-1:0]    idx,
  output logic [7:0]          byte_out
);

  localparam int PAY = payload_len(NUM_LEDS);

`ifdef LED_REPORT_HEX_EN
  logic [PAY*4-1:0] padded;

  always_comb begin
    padded                 = '0;
    padded[NUM_LEDS-1:0]   = snapshot;
  end
`endif

  always_comb begin
    byte_out = 8'h00;
    if (idx == IDX_W'(0)) begin
      byte_out = CHAR_L;
    end else if (idx == IDX_W'(1)) begin
      byte_out = CHAR_EQ;
    end else if (idx == IDX_W'(PAY + 2)) begin
      byte_out = CHAR_CR;
    end else if (idx == IDX_W'(PAY + 3)) begin
      byte_out = CHAR_LF;
    end else begin
      // Payload digit i sits at index i+2, most significant digit first.
      for (int i = 0; i < PAY; i++) begin
        if (idx == IDX_W'(i + 2)) begin
`ifdef LED_REPORT_HEX_EN
          byte_out = nib_to_hex(padded[(PAY-1-i)*4 +: 4]);
`else
          byte_out = snapshot[NUM_LEDS-1-i] ? CHAR_1 : CHAR_0;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/led_status_reporter.sv
// Reports the red-LED vector to the host as an ASCII line over a valid/ready byte stream.
// Payload is binary digits by default, hex digits when LED_REPORT_HEX_EN is defined.
module led_status_reporter
  import led_report_pkg::*;
#(
  parameter int         NUM_LEDS    = 10,
  parameter logic [7:0] QUERY_CHAR  = 8'h3F,
  parameter bit         AUTO_REPORT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] ledr_state,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [15:0]         report_count
);

  localparam int MSG_LEN = msg_len(NUM_LEDS);
  localparam int IDX_W   = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [NUM_LEDS-1:0] last_sent_q, last_sent_d;
  logic [15:0]         count_q, count_d;
  logic [NUM_LEDS-1:0] snapshot;
  logic                load_snap;
  logic                query;
  logic                changed;
  logic                xfer;
  logic [7:0]          fmt_byte;

  assign query    = rx_valid && (rx_data == QUERY_CHAR);
  assign changed  = AUTO_REPORT && (ledr_state != last_sent_q);
  assign busy     = (state_q == SEND);
  assign tx_valid = busy;
  assign xfer     = tx_valid && tx_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    last_sent_d = last_sent_q;
    count_d     = count_q;
    load_snap   = 1'b0;
    case (state_q)
      IDLE: begin
        if (query || changed || pending_q) begin
          load_snap   = 1'b1;
          last_sent_d = ledr_state;
          pending_d   = 1'b0;
          idx_d       = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Any number of queries during a message collapse into one follow-up.
        if (query) pending_d = 1'b1;
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            count_d = count_q + 16'd1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      last_sent_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      last_sent_q <= last_sent_d;
      count_q     <= count_d;
    end
  end

  // Snapshot is pure data: only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_snap) snapshot <= ledr_state;
  end

  led_report_fmt #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W)
  ) u_fmt (
    .snapshot (snapshot),
    .idx      (idx_q),
    .byte_out (fmt_byte)
  );

  assign tx_data      = busy ? fmt_byte : 8'h00;
  assign report_count = count_q;

endmodule

// File: tb/tb_led_status_reporter.sv
// Scoreboard bench: a query-only instance and an auto-report instance share clock, reset and tx_ready.
module tb_led_status_reporter;

`ifdef LED_REPORT_HEX_EN
  localparam int LEN = 7;
`else
  localparam int LEN = 14;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_ready;
  logic [9:0] q_ledr, a_ledr;
  logic [7:0] q_rx, a_rx;
  logic       q_rxv, a_rxv;
  logic [7:0] q_txd, a_txd;
  logic       q_txv, a_txv, q_busy, a_busy;
  logic [15:0] q_cnt, a_cnt;

  logic       mon_sel;
  logic [7:0] obs_data;
  logic       obs_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign obs_data  = mon_sel ? a_txd : q_txd;
  assign obs_valid = mon_sel ? a_txv : q_txv;

  led_status_reporter #(.NUM_LEDS(10), .QUERY_CHAR(8'h3F), .AUTO_REPORT(1'b0)) dut_q (
    .clk(clk), .rst_n(rst_n), .ledr_state(q_ledr), .rx_data(q_rx), .rx_valid(q_rxv),
    .tx_data(q_txd), .tx_valid(q_txv), .tx_ready(tx_ready), .busy(q_busy), .report_count(q_cnt)
  );

  led_status_reporter #(.NUM_LEDS(10), .QUERY_CHAR(8'h3F), .AUTO_REPORT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ledr_state(a_ledr), .rx_data(a_rx), .rx_valid(a_rxv),
    .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(tx_ready), .busy(a_busy), .report_count(a_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg(input logic [9:0] v);
    logic [11:0] w;
    logic [3:0]  n;
    w = {2'b00, v};
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h3D);
`ifdef LED_REPORT_HEX_EN
    for (int k = 2; k >= 0; k--) begin
      n = w[4*k +: 4];
      exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
    end
`else
    for (int k = 9; k >= 0; k--) exp_q.push_back(v[k] ? 8'h31 : 8'h30);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Entered at posedge+1; transfers are judged at negedge, committed at the next posedge.
  task automatic drain(input bit rnd, input int budget, output int ncyc);
    logic [7:0] prev_d;
    bit         hold;
    logic [7:0] e;
    hold   = 1'b0;
    prev_d = 8'h00;
    ncyc   = 0;
    while (exp_q.size() > 0 && ncyc < budget) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      ncyc++;
      if (hold) begin
        check("hold_valid", obs_valid, 1);
        check("hold_data", obs_data, prev_d);
      end
      if (obs_valid && tx_ready) begin
        e = exp_q.pop_front();
        check("tx_byte", obs_data, e);
        hold = 1'b0;
      end else begin
        hold   = obs_valid;
        prev_d = obs_data;
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    check("drain_done", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic watch_idle(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (q_txv || a_txv) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic query_q(input logic [7:0] b);
    q_rx  = b;
    q_rxv = 1'b1;
    @(posedge clk);
    #1;
    q_rxv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; tx_ready = 1'b1; mon_sel = 1'b0;
    q_ledr = '0; a_ledr = '0; q_rx = '0; a_rx = '0; q_rxv = 1'b0; a_rxv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txv", q_txv, 0);
    check("rst_busy", q_busy, 0);
    check("rst_txd", q_txd, 0);
    check("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;

    // Quiet after reset
    watch_idle("idle_200", 200);
    check("idle_cnt_q", q_cnt, 0);
    check("idle_cnt_a", a_cnt, 0);

    // Query-only instance: LED change and a non-query byte must not trigger
    mon_sel = 1'b0;
    @(posedge clk); #1;
    q_ledr = 10'h201;
    query_q(8'h41);
    repeat (4) @(posedge clk);
    #1;
    check("no_trigger", q_txv, 0);

    push_msg(10'h201);
    query_q(8'h3F);
    check("latency", q_txv, 1);
    drain(1'b0, 100, n);
    check("consecutive", n, LEN);
    check("busy_after", q_busy, 0);
    check("txv_after", q_txv, 0);
    check("count1", q_cnt, 1);

    // Backpressure
    push_msg(10'h201);
    query_q(8'h3F);
    drain(1'b1, 600, n);
    check("count2", q_cnt, 2);

    // Two queries mid-message coalesce into one follow-up with unchanged value
    push_msg(10'h201);
    push_msg(10'h201);
    query_q(8'h3F);
    fork
      drain(1'b0, 200, n);
      begin
        repeat (3) @(posedge clk);
        #2; q_rx = 8'h3F; q_rxv = 1'b1;
        @(posedge clk); #2; q_rxv = 1'b0;
        repeat (2) @(posedge clk);
        #2; q_rxv = 1'b1;
        @(posedge clk); #2; q_rxv = 1'b0;
      end
    join
    watch_idle("pend_idle", 30);
    check("count4", q_cnt, 4);

    // Auto-report: changes mid-message give exactly one follow-up with the latest value
    mon_sel = 1'b1;
    push_msg(10'h001);
    push_msg(10'h007);
    a_ledr = 10'h001;
    @(posedge clk); #1;
    check("auto_latency", a_txv, 1);
    fork
      drain(1'b0, 200, n);
      begin
        repeat (3) @(posedge clk);
        #2; a_ledr = 10'h003;
        repeat (3) @(posedge clk);
        #2; a_ledr = 10'h007;
      end
    join
    watch_idle("auto_idle", 30);
    check("auto_cnt2", a_cnt, 2);

    // Simultaneous query and change: one message
    push_msg(10'h0F0);
    a_ledr = 10'h0F0; a_rx = 8'h3F; a_rxv = 1'b1;
    @(posedge clk); #1;
    a_rxv = 1'b0;
    drain(1'b0, 100, n);
    watch_idle("simul_idle", 30);
    check("auto_cnt3", a_cnt, 3);

    // Asynchronous reset mid-message
    @(posedge clk); #1;
    a_ledr = 10'h155;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_txv", a_txv, 0);
    check("arst_busy", a_busy, 0);
    check("arst_txd", a_txd, 0);
    check("arst_cnt", a_cnt, 0);
    check("arst_cnt_q", q_cnt, 0);
    a_ledr = 10'h000;
    q_ledr = 10'h000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_idle("post_rst_idle", 50);

    // Payload encodings for all-ones and a sparse value
    mon_sel = 1'b0;
    q_ledr = 10'h3FF;
    push_msg(10'h3FF);
    query_q(8'h3F);
    drain(1'b0, 100, n);
    check("len_3ff", n, LEN);
    q_ledr = 10'h00A;
    push_msg(10'h00A);
    @(posedge clk); #1;
    query_q(8'h3F);
    drain(1'b0, 100, n);
    check("len_00a", n, LEN);
    check("final_cnt", q_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
